// File: rtl/serial_cmp_pkg.sv
// Shared types for the bit-serial magnitude comparator: FSM states, verdict
// encoding and the verdict-to-one-hot helper.
package serial_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        V_EQ = 2'd0,
        V_GT = 2'd1,
        V_LT = 2'd2
    } verdict_e;

    // One-hot ordering is {eq, gt, lt}.
    function automatic logic [2:0] verdict_to_onehot(input verdict_e v);
        logic [2:0] oh;
        oh = 3'b000;
        case (v)
            V_EQ:    oh = 3'b100;
            V_GT:    oh = 3'b010;
            V_LT:    oh = 3'b001;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/serial_cmp_cell.sv
// Single-bit compare cell: folds one bit pair into the running verdict.
// Combinational; the caller sequences it MSB first.
module serial_cmp_cell
    import serial_cmp_pkg::*;
(
    input  logic     a_bit_i,
    input  logic     b_bit_i,
    input  verdict_e prev_i,
    input  logic     invert_i,
    output verdict_e next_c
);

    logic a_wins;

    always_comb begin
        next_c = prev_i;
        // A set bit normally means A is larger; the signed MSB carries the opposite weight.
        a_wins = a_bit_i ^ invert_i;
        if ((prev_i == V_EQ) && (a_bit_i != b_bit_i)) begin
            next_c = a_wins ? V_GT : V_LT;
        end
    end

endmodule

// File: rtl/serial_mag_comparator.sv
// Bit-serial magnitude comparator, one bit per clock MSB first, with
// valid/ready operand and verdict handshakes. Define SERIAL_CMP_EARLY_EXIT_EN
// to finish on the first differing bit.
module serial_mag_comparator
    import serial_cmp_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter bit          SIGNED = 1'b0
)(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             a_in,
    input  logic [WIDTH-1:0]             b_in,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic                         eq,
    output logic                         gt,
    output logic                         lt,
    output logic [$clog2(WIDTH+1)-1:0]   bits_used
);

    localparam int unsigned BU_W  = $clog2(WIDTH + 1);
    localparam int unsigned IDX_W = $clog2(WIDTH);

`ifdef SERIAL_CMP_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    verdict_e           verdict_q, verdict_d;
    logic [BU_W-1:0]    bits_q, bits_d;
    logic               in_ready_q, in_ready_d;
    logic               res_valid_q, res_valid_d;
    logic [2:0]         oh_q, oh_d;
    verdict_e           verdict_c;
    logic               invert_c;
    logic               last_bit_c;

    assign invert_c = SIGNED && (idx_q == IDX_W'(WIDTH - 1));

    serial_cmp_cell u_cell (
        .a_bit_i  (a_q[WIDTH-1]),
        .b_bit_i  (b_q[WIDTH-1]),
        .prev_i   (verdict_q),
        .invert_i (invert_c),
        .next_c   (verdict_c)
    );

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        idx_d       = idx_q;
        verdict_d   = verdict_q;
        bits_d      = bits_q;
        in_ready_d  = in_ready_q;
        res_valid_d = res_valid_q;
        oh_d        = oh_q;
        last_bit_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d        = a_in;
                    b_d        = b_in;
                    idx_d      = IDX_W'(WIDTH - 1);
                    verdict_d  = V_EQ;
                    bits_d     = '0;
                    in_ready_d = 1'b0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                // Operands shift left so the bit under test is always the MSB.
                a_d        = a_q << 1;
                b_d        = b_q << 1;
                idx_d      = idx_q - IDX_W'(1);
                verdict_d  = verdict_c;
                bits_d     = bits_q + BU_W'(1);
                last_bit_c = (idx_q == '0) || (EARLY_EXIT && (verdict_c != V_EQ));
                if (last_bit_c) begin
                    state_d     = DONE;
                    res_valid_d = 1'b1;
                    oh_d        = verdict_to_onehot(verdict_c);
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d     = IDLE;
                    res_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            idx_q       <= '0;
            verdict_q   <= V_EQ;
            bits_q      <= '0;
            in_ready_q  <= 1'b1;
            res_valid_q <= 1'b0;
            oh_q        <= 3'b000;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            idx_q       <= idx_d;
            verdict_q   <= verdict_d;
            bits_q      <= bits_d;
            in_ready_q  <= in_ready_d;
            res_valid_q <= res_valid_d;
            oh_q        <= oh_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign res_valid = res_valid_q;
    assign eq        = oh_q[2];
    assign gt        = oh_q[1];
    assign lt        = oh_q[0];
    assign bits_used = bits_q;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Bench for serial_mag_comparator: an unsigned and a signed 8-bit instance,
// table vectors, backpressure/reset sequences and a random scoreboard run.
module tb_serial_mag_comparator;

    localparam int W = 8;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] oh;
        int         pos;
    } vec_t;

    typedef struct {
        logic [2:0] oh;
        int         bits;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       in_valid, in_ready, res_valid, res_ready;
    logic [7:0] a_in, b_in;
    logic       eq, gt, lt;
    logic [3:0] bits_used;

    logic       s_in_valid, s_in_ready, s_res_valid, s_res_ready;
    logic [7:0] s_a, s_b;
    logic       s_eq, s_gt, s_lt;
    logic [3:0] s_bits;

    int   total;
    int   bad;
    int   cyc;
    int   acc_edge;
    logic rv_prev;
    int   rr_mode;
    logic rr_manual;
    exp_t sb_q[$];
    vec_t vecs[10];

    serial_mag_comparator #(.WIDTH(W), .SIGNED(1'b0)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .res_valid(res_valid), .res_ready(res_ready),
        .eq(eq), .gt(gt), .lt(lt), .bits_used(bits_used)
    );

    serial_mag_comparator #(.WIDTH(W), .SIGNED(1'b1)) u_dut_s (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .a_in(s_a), .b_in(s_b), .res_valid(s_res_valid), .res_ready(s_res_ready),
        .eq(s_eq), .gt(s_gt), .lt(s_lt), .bits_used(s_bits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int bits_for(input int pos);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        return (pos < 0) ? W : W - pos;
`else
        return W;
`endif
    endfunction

    function automatic int first_diff(input logic [7:0] a, input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            if (a[i] != b[i]) return i;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                rv_prev = 1'b0;
            end else begin
                if (in_valid && in_ready) acc_edge = cyc + 1;
                if (res_valid && !rv_prev) begin
                    if (sb_q.size() == 0) chk("unexpected_result", 1, 0);
                    else chk("latency", cyc - acc_edge, sb_q[0].bits);
                end
                if (res_valid && res_ready) begin
                    if (sb_q.size() == 0) begin
                        chk("pop_empty", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("verdict", int'({eq, gt, lt}), int'(e.oh));
                        chk("bits_used", int'(bits_used), e.bits);
                        chk("onehot", int'(eq) + int'(gt) + int'(lt), 1);
                    end
                end
                rv_prev = res_valid;
            end
        end
    endtask

    task automatic rr_drive();
        forever begin
            @(posedge clk);
            #1;
            case (rr_mode)
                0:       res_ready = 1'b1;
                1:       res_ready = 1'($urandom_range(0, 1));
                default: res_ready = rr_manual;
            endcase
        end
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] oh, input int bits, input bit push);
        exp_t e;
        bit   ok;
        @(posedge clk);
        #1;
        a_in     = a;
        b_in     = b;
        in_valid = 1'b1;
        ok       = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk("accept_timeout", 0, 1);
        end else if (push) begin
            e.oh   = oh;
            e.bits = bits;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_rv();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (res_valid) return;
        end
        chk("res_valid_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0) break;
        end
        chk("drain", sb_q.size(), 0);
    endtask

    task automatic s_cmp(input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] oh, input int bits);
        bit ok;
        @(posedge clk);
        #1;
        s_a        = a;
        s_b        = b;
        s_in_valid = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (s_res_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk("signed_timeout", 0, 1);
        end else begin
            chk("signed_verdict", int'({s_eq, s_gt, s_lt}), int'(oh));
            chk("signed_bits", int'(s_bits), bits);
        end
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic [2:0] roh;
        bit         quiet;

        total = 0; bad = 0; acc_edge = 0; rv_prev = 1'b0;
        rr_mode = 0; rr_manual = 1'b1; res_ready = 1'b1;
        in_valid = 1'b0; a_in = '0; b_in = '0;
        s_in_valid = 1'b0; s_a = '0; s_b = '0; s_res_ready = 1'b1;

        vecs[0] = '{8'h5A, 8'h5A, 3'b100, -1};
        vecs[1] = '{8'h80, 8'h7F, 3'b010,  7};
        vecs[2] = '{8'h01, 8'h02, 3'b001,  1};
        vecs[3] = '{8'hFF, 8'h00, 3'b010,  7};
        vecs[4] = '{8'h00, 8'hFF, 3'b001,  7};
        vecs[5] = '{8'h7F, 8'h80, 3'b001,  7};
        vecs[6] = '{8'h00, 8'h00, 3'b100, -1};
        vecs[7] = '{8'h01, 8'h00, 3'b010,  0};
        vecs[8] = '{8'h5A, 8'h5B, 3'b001,  0};
        vecs[9] = '{8'h40, 8'h20, 3'b010,  6};

        rst = 1'b1;
        fork
            monitor();
            rr_drive();
        join_none

        repeat (2) @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_flags", int'({eq, gt, lt}), 0);
        chk("rst_bits", int'(bits_used), 0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].oh, bits_for(vecs[i].pos), 1'b1);
        end
        drain();

        // Backpressure: verdict holds, no new accept while DONE.
        rr_manual = 1'b0;
        rr_mode   = 2;
        send(8'h80, 8'h7F, 3'b010, bits_for(7), 1'b1);
        wait_rv();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", int'(res_valid), 1);
            chk("bp_flags", int'({eq, gt, lt}), 3'b010);
            chk("bp_in_ready", int'(in_ready), 0);
            if (i == 2) begin
                a_in = 8'h01; b_in = 8'h02; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        rr_manual = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_in_ready", int'(in_ready), 1);
        chk("bp_release_valid", int'(res_valid), 0);
        quiet = 1'b1;
        repeat (W + 3) begin
            @(negedge clk);
            if (res_valid) quiet = 1'b0;
        end
        chk("bp_pulse_ignored", int'(quiet), 1);
        chk("bp_queue", sb_q.size(), 0);
        rr_mode = 0;

        // Asynchronous reset in the middle of a shift.
        send(8'h33, 8'h44, 3'b001, W, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_in_ready", int'(in_ready), 1);
        chk("arst_res_valid", int'(res_valid), 0);
        chk("arst_flags", int'({eq, gt, lt}), 0);
        chk("arst_bits", int'(bits_used), 0);
        @(negedge clk);
        rst = 1'b0;
        send(8'h01, 8'h02, 3'b001, bits_for(1), 1'b1);
        drain();

        // Signed instance.
        s_cmp(8'hFF, 8'h00, 3'b001, bits_for(7));
        s_cmp(8'h7F, 8'h80, 3'b010, bits_for(7));
        s_cmp(8'h80, 8'h7F, 3'b001, bits_for(7));
        s_cmp(8'h01, 8'h02, 3'b001, bits_for(1));
        s_cmp(8'hC3, 8'hC3, 3'b100, bits_for(-1));

        // Random pairs with random downstream stalls.
        rr_mode = 1;
        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? ra : 8'($urandom);
            if (ra == rb)     roh = 3'b100;
            else if (ra > rb) roh = 3'b010;
            else              roh = 3'b001;
            send(ra, rb, roh, bits_for(first_diff(ra, rb)), 1'b1);
        end
        drain();
        rr_mode = 0;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_mag_comparator.md
Name: serial_mag_comparator

Overview:
- Multi-bit magnitude comparator built from one compare cell used over time, one bit per clock, MSB first.
- Accepts two WIDTH-bit operands through a valid/ready handshake and shifts them out internally.
- Combines the per-bit eq/gt/lt relation into a running verdict.
- Returns one-hot eq/gt/lt through a second valid/ready handshake. Used where a wide parallel comparator costs too much area.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32.
- SIGNED, 0, 1 = two's-complement compare (MSB relation inverted); 0 = unsigned.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair a_in/b_in is valid.
- in_ready  output  1  block can accept an operand pair.
- a_in  input  WIDTH  operand A.
- b_in  input  WIDTH  operand B.
- res_valid  output  1  verdict valid.
- res_ready  input  1  downstream accepts the verdict.
- eq  output  1  A == B.
- gt  output  1  A > B.
- lt  output  1  A < B.
- bits_used  output  $clog2(WIDTH+1)  number of bit positions examined for this verdict.

Behaviour:
- Reset (asynchronous, any time, including mid-compare):
  - State goes to IDLE; the operation in flight is discarded.
  - in_ready=1, res_valid=0, eq=gt=lt=0, bits_used=0.
  - Shift registers and bit index are cleared.
- FSM IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at a rising edge: capture a_in/b_in, set index=WIDTH-1, set running verdict to EQ, go to SHIFT.
- FSM SHIFT:
  - in_ready=0. Each cycle compare bit a[index] with b[index].
  - If the running verdict is EQ and the bits differ, the verdict becomes GT or LT.
  - For SIGNED=1 at index WIDTH-1 only, the GT/LT sense is swapped.
  - Once the verdict is not EQ it is sticky.
  - Increment bits_used each cycle.
  - After bit 0 is processed, go to DONE.
- FSM DONE:
  - res_valid=1; eq/gt/lt are one-hot and stable while res_valid&&!res_ready.
  - On res_valid&&res_ready: go to IDLE, res_valid=0.
  - eq/gt/lt keep their last value until the next verdict; consumers qualify them with res_valid.
- Latency: an operand pair accepted at edge k gives res_valid high after edge k+WIDTH.
- Throughput: one compare per WIDTH+2 cycles minimum. No new operand is accepted until the verdict handshake completes (no overlap).
- in_valid while busy: ignored; the operand source must hold it.
- res_ready held high: DONE lasts exactly one cycle.
- Equal operands: eq=1, bits_used=WIDTH.
- Operands all-ones vs all-zeros:
  - unsigned gives gt=1;
  - SIGNED=1 gives lt=1, because -1 < 0.

Optional Feature:
- Macro SERIAL_CMP_EARLY_EXIT_EN.
- When defined: in SHIFT, the first differing bit at position p moves the FSM to DONE immediately.
  - res_valid is high after edge k+(WIDTH-p).
  - bits_used = WIDTH-p.
  - Equal operands still take WIDTH cycles.
- When undefined: always WIDTH shift cycles, bits_used=WIDTH for every verdict; verdicts are identical in both builds.

Decomposition:
- Package serial_cmp_pkg:
  - state enum {IDLE, SHIFT, DONE};
  - verdict enum {V_EQ, V_GT, V_LT};
  - function verdict_to_onehot.
- Sub-module serial_cmp_cell: combinational. Inputs are a_bit, b_bit, prev verdict and an invert flag; output is the next verdict. It holds all per-bit relation logic; the top owns the FSM, shift registers, counter and handshakes.

Test Plan:
- WIDTH=8, unsigned, A=0x5A, B=0x5A, res_ready=1 -> res_valid 8 cycles after accept; eq=1, gt=lt=0, bits_used=8.
- WIDTH=8, unsigned, A=0x80, B=0x7F -> gt=1.
  - With EARLY_EXIT: res_valid after 1 cycle, bits_used=1.
  - Without: after 8 cycles, bits_used=8.
- WIDTH=8, SIGNED=1, A=0xFF, B=0x00 -> lt=1; same operands with SIGNED=0 -> gt=1.
- Backpressure: res_ready=0 for 5 cycles after res_valid -> res_valid and eq/gt/lt hold; in_ready stays 0; a pulsed in_valid is not accepted. Raise res_ready -> in_ready=1 next cycle.
- Reset asserted asynchronously 3 cycles into SHIFT -> outputs at reset values immediately. Next operands A=0x01, B=0x02 -> lt=1, with no residue from the aborted compare.
- Random back-to-back pairs (1000 iterations, random res_ready) -> every verdict matches a reference compare; exactly one of eq/gt/lt is high per verdict.
